uart_frame_parser: RTL and testbench
====================================

UART_FRAME_PARSER -- requirements
Module: uart_frame_parser

Interface
REQ-001 SHALL have parameter HDR, default 8'hA5, frame header byte.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 50000, inter-byte timeout in clk cycles (range 2..65535).
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port rx_dat  input  8  received byte from UART receiver; valid only when rx_ok=1.
REQ-006 SHALL have port rx_ok  input  1  one-cycle byte-valid strobe from UART receiver.
REQ-007 SHALL have port wr_en  output  1  one-cycle register-write strobe.
REQ-008 SHALL have port wr_addr  output  8  register address; valid when wr_en=1.
REQ-009 SHALL have port wr_data  output  8  register data; valid when wr_en=1.
REQ-010 SHALL have port frm_err  output  1  one-cycle frame-error strobe.
REQ-011 SHALL have port err_cnt  output  8  saturating count of frame errors.
REQ-012 SHALL have port busy  output  1  high while the FSM is in any state other than IDLE.

Function
REQ-013 SHALL parse 4-byte frames: HDR, ADDR, DATA, CHK, with CHK = (ADDR + DATA) mod 256; HDR is excluded from the sum.
REQ-014 SHALL implement FSM states IDLE, GET_ADDR, GET_DATA, GET_CHK; it advances only on cycles with rx_ok=1.
REQ-015 IDLE: on rx_ok with rx_dat==HDR SHALL go to GET_ADDR; other bytes SHALL be discarded silently with no error and no state change.
REQ-016 GET_ADDR: on rx_ok SHALL latch rx_dat as the address and go to GET_DATA; a byte equal to HDR SHALL be treated as a normal address byte.
REQ-017 GET_DATA: on rx_ok SHALL latch rx_dat as the data and go to GET_DATA->GET_CHK.
REQ-018 GET_CHK: on rx_ok SHALL compare rx_dat with the 8-bit sum and return to IDLE in either outcome; the CHK byte is never reinterpreted as a header.
REQ-019 On a checksum match, wr_en SHALL be 1 for exactly the cycle after the CHK rx_ok (latency 1), and wr_addr/wr_data SHALL update in that same cycle.
REQ-020 wr_addr/wr_data SHALL hold their last values between writes and SHALL NOT change on error frames.
REQ-021 On a checksum mismatch, frm_err SHALL be 1 for the cycle after the CHK rx_ok, and wr_en SHALL stay 0.
REQ-022 An inter-byte timer SHALL clear on every rx_ok and increment on each other cycle while the FSM is not in IDLE; it SHALL be held at 0 in IDLE.
REQ-023 When the timer reaches TIMEOUT_CYC-1 in a non-IDLE state without rx_ok, the FSM SHALL return to IDLE and frm_err SHALL pulse on the next cycle.
REQ-024 If rx_ok coincides with the timeout cycle, rx_ok SHALL win: the byte is processed normally and the timer clears.
REQ-025 err_cnt SHALL increment by 1 on each frm_err pulse and saturate at 8'hFF.
REQ-026 wr_en and frm_err SHALL never be asserted in the same cycle.
REQ-027 Back-to-back frames with no idle gap between bytes SHALL be accepted without byte loss.

Reset
REQ-028 While rstn=0: FSM=IDLE, timer=0, wr_en=0, frm_err=0, wr_addr=8'h00, wr_data=8'h00, err_cnt=8'h00, busy=0.
REQ-029 Reset asserted mid-frame SHALL abort the frame with no wr_en or frm_err pulse; the first byte after release SHALL be parsed from IDLE.

Verification
REQ-030 Bytes A5,10,20,30 -> single wr_en pulse one cycle after the 4th rx_ok, wr_addr=10, wr_data=20; err_cnt=0.
REQ-031 Bytes A5,10,20,31 -> frm_err pulse, no wr_en, err_cnt=1, wr_addr/wr_data unchanged.
REQ-032 Bytes 00,FF,A5,80,90,10 -> 00 and FF discarded; wr_en with wr_addr=80, wr_data=90 (sum 0x110 wraps to 10).
REQ-033 A5,10 then no rx_ok for TIMEOUT_CYC cycles -> FSM returns to IDLE, one frm_err pulse, err_cnt+1; following A5,01,02,03 -> wr_en.
REQ-034 300 bad-checksum frames -> err_cnt stops at FF; rstn pulse during GET_DATA -> all outputs at reset values, no strobes.
REQ-035 Two frames back-to-back, one byte per cycle (A5,01,01,02,A5,02,02,04) -> two wr_en pulses with correct address/data pairs.

Source files
------------

// File: rtl/uart_frame_parser.sv
// Parses HDR/ADDR/DATA/CHK frames from a UART byte stream into register writes.
// Frames with a bad checksum or an inter-byte timeout produce a frame-error strobe instead.
module uart_frame_parser #(
    parameter logic [7:0]  HDR         = 8'hA5,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [7:0] rx_dat,
    input  logic       rx_ok,
    output logic       wr_en,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       frm_err,
    output logic [7:0] err_cnt,
    output logic       busy
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] GET_ADDR = 2'd1;
    localparam logic [1:0] GET_DATA = 2'd2;
    localparam logic [1:0] GET_CHK  = 2'd3;

    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYC - 1);

    logic [1:0]  state_reg, state_next;
    logic [15:0] timer_reg, timer_next;
    logic [7:0]  addr_reg, addr_next;
    logic [7:0]  data_reg, data_next;
    logic [7:0]  sum;
    logic        wr_pulse;
    logic        err_pulse;
    logic        timeout;

    assign sum     = addr_reg + data_reg;
    assign timeout = (state_reg != IDLE) && !rx_ok && (timer_reg == TIMER_LAST);
    assign busy    = (state_reg != IDLE);

    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        data_next  = data_reg;
        wr_pulse   = 1'b0;
        err_pulse  = 1'b0;

        if (state_reg == IDLE || rx_ok) begin
            timer_next = 16'd0;
        end else begin
            timer_next = timer_reg + 16'd1;
        end

        case (state_reg)
            IDLE: begin
                if (rx_ok && rx_dat == HDR) begin
                    state_next = GET_ADDR;
                end
            end
            GET_ADDR: begin
                if (rx_ok) begin
                    addr_next  = rx_dat;
                    state_next = GET_DATA;
                end
            end
            GET_DATA: begin
                if (rx_ok) begin
                    data_next  = rx_dat;
                    state_next = GET_CHK;
                end
            end
            default: begin
                // The checksum byte always ends the frame, even if it equals HDR.
                if (rx_ok) begin
                    state_next = IDLE;
                    if (rx_dat == sum) begin
                        wr_pulse = 1'b1;
                    end else begin
                        err_pulse = 1'b1;
                    end
                end
            end
        endcase

        // timeout only fires without rx_ok, so an arriving byte always wins
        if (timeout) begin
            state_next = IDLE;
            timer_next = 16'd0;
            err_pulse  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= IDLE;
            timer_reg <= 16'd0;
            addr_reg  <= 8'h00;
            data_reg  <= 8'h00;
            wr_en     <= 1'b0;
            frm_err   <= 1'b0;
            wr_addr   <= 8'h00;
            wr_data   <= 8'h00;
            err_cnt   <= 8'h00;
        end else begin
            state_reg <= state_next;
            timer_reg <= timer_next;
            addr_reg  <= addr_next;
            data_reg  <= data_next;
            wr_en     <= wr_pulse;
            frm_err   <= err_pulse;
            if (wr_pulse) begin
                wr_addr <= addr_reg;
                wr_data <= data_reg;
            end
            if (err_pulse && err_cnt != 8'hFF) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Self-checking bench for uart_frame_parser: directed and randomized byte streams
// compared cycle by cycle against a queue-based frame model.
module tb_uart_frame_parser;

    localparam logic [7:0] HDR = 8'hA5;
    localparam int         TO  = 20;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [7:0] rx_dat = 8'h00;
    logic       rx_ok = 1'b0;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       frm_err;
    logic [7:0] err_cnt;
    logic       busy;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [7:0] frame_q[$];
    int         gap = 0;
    logic       exp_wr_en = 1'b0;
    logic       exp_frm_err = 1'b0;
    logic [7:0] exp_addr = 8'h00;
    logic [7:0] exp_data = 8'h00;
    logic [7:0] exp_cnt = 8'h00;
    logic       exp_busy = 1'b0;

    wire [26:0] obs_v = {wr_en, frm_err, wr_addr, wr_data, err_cnt, busy};
    wire [26:0] exp_v = {exp_wr_en, exp_frm_err, exp_addr, exp_data, exp_cnt, exp_busy};

    uart_frame_parser #(.HDR(HDR), .TIMEOUT_CYC(TO)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .rx_dat  (rx_dat),
        .rx_ok   (rx_ok),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .frm_err (frm_err),
        .err_cnt (err_cnt),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        frame_q.delete();
        gap         = 0;
        exp_wr_en   = 1'b0;
        exp_frm_err = 1'b0;
        exp_addr    = 8'h00;
        exp_data    = 8'h00;
        exp_cnt     = 8'h00;
        exp_busy    = 1'b0;
    endtask

    task automatic model_error();
        exp_frm_err = 1'b1;
        if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
        frame_q.delete();
        gap = 0;
    endtask

    // Expected registered outputs after a clock edge that saw (ok, dat).
    task automatic model_update(input logic ok, input logic [7:0] dat);
        logic [7:0] s;
        exp_wr_en   = 1'b0;
        exp_frm_err = 1'b0;
        if (ok) begin
            gap = 0;
            if (frame_q.size() == 0) begin
                if (dat == HDR) frame_q.push_back(dat);
            end else begin
                frame_q.push_back(dat);
                if (frame_q.size() == 4) begin
                    s = frame_q[1] + frame_q[2];
                    if (s == frame_q[3]) begin
                        exp_wr_en = 1'b1;
                        exp_addr  = frame_q[1];
                        exp_data  = frame_q[2];
                        frame_q.delete();
                    end else begin
                        model_error();
                    end
                end
            end
        end else if (frame_q.size() != 0) begin
            gap++;
            if (gap == TO) model_error();
        end
        exp_busy = (frame_q.size() != 0);
    endtask

    task automatic step(input logic ok, input logic [7:0] dat);
        rx_ok  = ok;
        rx_dat = dat;
        @(posedge clk);
        model_update(ok, dat);
        #1;
        rx_ok  = 1'b0;
        rx_dat = 8'($urandom);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (obs_v !== 27'd0) begin
            errors++;
            $display("FAIL reset_state got=%h exp=%h", obs_v, 27'd0);
        end
        rstn = 1'b1;
        step(1'b0, 8'h00);
        checks++;
        if (obs_v !== exp_v) begin
            errors++;
            $display("FAIL reset_release got=%h exp=%h", obs_v, exp_v);
        end
    endtask

    task automatic test_good_frame();
        logic [7:0] seq[4] = '{8'hA5, 8'h10, 8'h20, 8'h30};
        int pulses = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, seq[i]);
            if (wr_en) pulses++;
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL good_frame byte=%0d got=%h exp=%h", i, obs_v, exp_v);
            end
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'h00);
            if (wr_en) pulses++;
        end
        checks++;
        if (pulses != 1 || wr_addr !== 8'h10 || wr_data !== 8'h20 || err_cnt !== 8'h00) begin
            errors++;
            $display("FAIL good_frame_result got pulses=%0d addr=%h data=%h cnt=%h exp 1/10/20/00",
                     pulses, wr_addr, wr_data, err_cnt);
        end
    endtask

    task automatic test_bad_frame();
        logic [7:0] seq[4] = '{8'hA5, 8'h10, 8'h20, 8'h31};
        for (int i = 0; i < 4; i++) begin
            step(1'b1, seq[i]);
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL bad_frame byte=%0d got=%h exp=%h", i, obs_v, exp_v);
            end
        end
        checks++;
        if (frm_err !== 1'b1 || wr_en !== 1'b0 || err_cnt !== 8'h01 || wr_addr !== 8'h10 || wr_data !== 8'h20) begin
            errors++;
            $display("FAIL bad_frame_result got err=%b wr=%b cnt=%h addr=%h data=%h exp 1/0/01/10/20",
                     frm_err, wr_en, err_cnt, wr_addr, wr_data);
        end
    endtask

    task automatic test_discard();
        logic [7:0] seq[6] = '{8'h00, 8'hFF, 8'hA5, 8'h80, 8'h90, 8'h10};
        for (int i = 0; i < 6; i++) begin
            step(1'b1, seq[i]);
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL discard byte=%0d got=%h exp=%h", i, obs_v, exp_v);
            end
        end
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== 8'h80 || wr_data !== 8'h90) begin
            errors++;
            $display("FAIL discard_write got wr=%b addr=%h data=%h exp 1/80/90", wr_en, wr_addr, wr_data);
        end
    endtask

    task automatic test_timeout();
        logic [7:0] good[4] = '{8'hA5, 8'h01, 8'h02, 8'h03};
        int pulses = 0;
        logic [7:0] cnt0 = exp_cnt;
        step(1'b1, 8'hA5);
        step(1'b1, 8'h10);
        for (int i = 0; i < TO + 3; i++) begin
            step(1'b0, 8'h00);
            if (frm_err) pulses++;
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL timeout cyc=%0d got=%h exp=%h", i, obs_v, exp_v);
            end
        end
        checks++;
        if (pulses != 1 || busy !== 1'b0 || err_cnt !== cnt0 + 8'd1) begin
            errors++;
            $display("FAIL timeout_result got pulses=%0d busy=%b cnt=%h exp 1/0/%h", pulses, busy, err_cnt, cnt0 + 8'd1);
        end
        for (int i = 0; i < 4; i++) step(1'b1, good[i]);
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== 8'h01 || wr_data !== 8'h02) begin
            errors++;
            $display("FAIL timeout_recover got wr=%b addr=%h data=%h exp 1/01/02", wr_en, wr_addr, wr_data);
        end
    endtask

    // A byte arriving exactly on the would-be timeout cycle must be accepted.
    task automatic test_timeout_race();
        step(1'b1, 8'hA5);
        for (int i = 0; i < TO - 1; i++) step(1'b0, 8'h00);
        step(1'b1, 8'h44);
        checks++;
        if (obs_v !== exp_v || frm_err !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL timeout_race got=%h exp=%h", obs_v, exp_v);
        end
        for (int i = 0; i < TO - 1; i++) step(1'b0, 8'h00);
        step(1'b1, 8'h55);
        step(1'b1, 8'h99);
        checks++;
        if (obs_v !== exp_v || wr_en !== 1'b1 || wr_addr !== 8'h44 || wr_data !== 8'h55) begin
            errors++;
            $display("FAIL timeout_race_write got=%h exp=%h", obs_v, exp_v);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] seq[8] = '{8'hA5, 8'h01, 8'h01, 8'h02, 8'hA5, 8'h02, 8'h02, 8'h04};
        int pulses = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, seq[i]);
            if (wr_en) pulses++;
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL back_to_back byte=%0d got=%h exp=%h", i, obs_v, exp_v);
            end
        end
        checks++;
        if (pulses != 2 || wr_addr !== 8'h02 || wr_data !== 8'h02) begin
            errors++;
            $display("FAIL back_to_back_result got pulses=%0d addr=%h data=%h exp 2/02/02", pulses, wr_addr, wr_data);
        end
    endtask

    task automatic test_random();
        logic [7:0] fr[4];
        int bad = 0;
        for (int f = 0; f < 150; f++) begin
            fr[0] = HDR;
            fr[1] = 8'($urandom);
            fr[2] = 8'($urandom);
            fr[3] = fr[1] + fr[2];
            if ($urandom_range(3) == 0) fr[3] = fr[3] ^ 8'($urandom_range(255, 1));
            for (int n = 0; n < int'($urandom_range(2)); n++) begin
                step(1'b1, 8'($urandom));
                if (obs_v !== exp_v) bad++;
            end
            for (int b = 0; b < 4; b++) begin
                int g = ($urandom_range(24) == 0) ? TO + 1 : int'($urandom_range(3));
                for (int k = 0; k < g; k++) begin
                    step(1'b0, 8'($urandom));
                    if (obs_v !== exp_v) bad++;
                end
                step(1'b1, fr[b]);
                if (obs_v !== exp_v) bad++;
                checks++;
                if (obs_v !== exp_v) begin
                    errors++;
                    $display("FAIL random frame=%0d byte=%0d got=%h exp=%h", f, b, obs_v, exp_v);
                end
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL random_gaps got %0d mismatching cycles exp 0", bad);
        end
    endtask

    task automatic test_saturate();
        for (int f = 0; f < 300; f++) begin
            step(1'b1, HDR);
            step(1'b1, 8'h01);
            step(1'b1, 8'h01);
            step(1'b1, 8'h07);
        end
        checks++;
        if (err_cnt !== 8'hFF || obs_v !== exp_v) begin
            errors++;
            $display("FAIL saturate got cnt=%h vec=%h exp cnt=FF vec=%h", err_cnt, obs_v, exp_v);
        end
    endtask

    task automatic test_reset_mid_frame();
        int strobes = 0;
        step(1'b1, HDR);
        step(1'b1, 8'h11);
        #3;
        rstn = 1'b0;
        #1;
        checks++;
        if (obs_v !== 27'd0) begin
            errors++;
            $display("FAIL reset_async got=%h exp=%h", obs_v, 27'd0);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (wr_en || frm_err) strobes++;
            if (obs_v !== 27'd0) strobes++;
        end
        rstn = 1'b1;
        model_reset();
        checks++;
        if (strobes != 0) begin
            errors++;
            $display("FAIL reset_hold got %0d bad cycles exp 0", strobes);
        end
        step(1'b1, 8'h22);
        step(1'b1, 8'h33);
        checks++;
        if (obs_v !== exp_v || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort got=%h exp=%h", obs_v, exp_v);
        end
        step(1'b1, HDR);
        step(1'b1, 8'h05);
        step(1'b1, 8'h06);
        step(1'b1, 8'h0B);
        checks++;
        if (obs_v !== exp_v || wr_en !== 1'b1 || wr_addr !== 8'h05) begin
            errors++;
            $display("FAIL reset_resume got=%h exp=%h", obs_v, exp_v);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_frame();
        test_discard();
        test_timeout();
        test_timeout_race();
        test_back_to_back();
        test_random();
        test_saturate();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
